// File: rtl/mic_ram_pkg.sv
// mic_ram_pkg
// Shared definitions for the microphone RAM writer:
//   - state_e      : write-scheduler states (FILL, STALL, HDR)
//   - HDR_MAGIC    : marker placed in the upper half of a half-buffer header word
//   - field widths : layout of the packed 32-bit RAM word
//   - pack_sample / pack_header : build the two kinds of RAM word
package mic_ram_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_STALL = 2'd1,
        ST_HDR   = 2'd2
    } state_e;

    localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

    localparam int SAMPLE_W = 16;
    localparam int SEQ_W    = 8;
    localparam int MIC_ID_W = 4;
    localparam int WORD_W   = 32;

    // {frame_seq, 4'd0, mic_id, sample}
    function automatic logic [WORD_W-1:0] pack_sample(
        input logic [SEQ_W-1:0]    seq,
        input logic [MIC_ID_W-1:0] mic_id,
        input logic [SAMPLE_W-1:0] sample
    );
        return {seq, 4'd0, mic_id, sample};
    endfunction

    // {magic, 8'd0, frame_seq}
    function automatic logic [WORD_W-1:0] pack_header(
        input logic [SEQ_W-1:0] seq
    );
        return {HDR_MAGIC, 8'd0, seq};
    endfunction

endpackage

// File: rtl/mic_rr_arbiter.sv
// mic_rr_arbiter
// N-wide round-robin arbiter. The search starts at the channel after the
// last one granted; at most one grant per cycle.
// Ports:
//   clk      : clock
//   srst_i   : synchronous active-high reset (pointer back to channel 0)
//   en_i     : grant allowed this cycle
//   req_i    : request vector (one bit per channel)
//   gnt_o    : one-hot grant
//   idx_o    : encoded index of the granted channel
//   any_o    : a grant was issued this cycle
module mic_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   cand;

    // Walk the channels in order ptr, ptr+1, ... (mod N); first requester wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!any_o && en_i && req_i[cand[IDX_W-1:0]]) begin
                any_o                    = 1'b1;
                gnt_o[cand[IDX_W-1:0]]   = 1'b1;
                idx_o                    = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_o) begin
            ptr_d = (idx_o == IDX_W'(N-1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mic_ram_writer.sv
// mic_ram_writer
// Captures 16-bit decimation-filter outputs from MIC_N microphones,
// round-robin schedules them onto a single RAM write port and fills the RAM
// as two ping-pong half-buffers handed to the CPU with a ready/ack handshake.
// Optional feature: define MIC_RAM_WRITER_HEADER_EN to put a header word
// {16'hA5A5, 8'd0, frame_seq} at index 0 of every half-buffer.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enable            : capture enable; low = new samples ignored
//   mic_data          : channel j at [16j+15:16j]
//   mic_valid         : per-channel sample strobe
//   frame_ack         : one-cycle pulse, bit h releases half h
//   ram_address       : {half, index}
//   ram_chipselect    : mirrors ram_write
//   ram_write         : one-cycle write strobe
//   ram_writedata     : packed word
//   ram_byteenable    : always 4'hF
//   frame_ready       : bit h = half h full, awaiting ack
//   drop_count        : saturating count of discarded samples
//   overflow          : sticky, set on the first drop
module mic_ram_writer
    import mic_ram_pkg::*;
#(
    parameter int MIC_N  = 2,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [16*MIC_N-1:0]   mic_data,
    input  logic [MIC_N-1:0]      mic_valid,
    input  logic [1:0]            frame_ack,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [31:0]           ram_writedata,
    output logic [3:0]            ram_byteenable,
    output logic [1:0]            frame_ready,
    output logic [15:0]           drop_count,
    output logic                  overflow
);

    localparam int IW = ADDR_W - 1;
    localparam int GW = (MIC_N > 1) ? $clog2(MIC_N) : 1;
    localparam logic [IW-1:0] IDX_LAST = '1;

`ifdef MIC_RAM_WRITER_HEADER_EN
    localparam state_e ENTRY_ST = ST_HDR;
`else
    localparam state_e ENTRY_ST = ST_FILL;
`endif

    state_e                state_q, state_d;
    logic                  cur_half_q, cur_half_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [1:0]            ready_q, ready_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic                  overflow_q, overflow_d;

    logic [MIC_N-1:0]      pend_q, pend_d;
    logic [SAMPLE_W-1:0]   hold_q [MIC_N];
    logic [SAMPLE_W-1:0]   sample_in [MIC_N];

    logic [MIC_N-1:0]      new_valid;
    logic [MIC_N-1:0]      drop_vec;
    logic [MIC_N-1:0]      gnt;
    logic [GW-1:0]         gnt_idx;
    logic                  gnt_any;
    logic                  arb_en;
    logic                  stall_drop;
    logic                  other_free;
    logic [4:0]            drop_n;
    logic [16:0]           drop_sum;

    assign new_valid = mic_valid & {MIC_N{enable}};
    // The header cycle owns the write port, so nothing is granted then.
    assign arb_en    = (state_q != ST_HDR);

    mic_rr_arbiter #(
        .N     (MIC_N),
        .IDX_W (GW)
    ) u_arb (
        .clk    (clk),
        .srst_i (reset),
        .en_i   (arb_en),
        .req_i  (pend_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // Per-channel slicing and overwrite-drop detection. A new sample on a
    // channel whose pending sample is being granted this cycle is not a drop.
    for (genvar gi = 0; gi < MIC_N; gi++) begin : g_chan
        assign sample_in[gi] = mic_data[SAMPLE_W*gi +: SAMPLE_W];
        assign drop_vec[gi]  = new_valid[gi] & pend_q[gi] & ~gnt[gi];
    end

    assign pend_d = new_valid | (pend_q & ~gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            for (int j = 0; j < MIC_N; j++) begin
                hold_q[j] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int j = 0; j < MIC_N; j++) begin
                if (new_valid[j]) begin
                    hold_q[j] <= sample_in[j];
                end
            end
        end
    end

    // Write scheduler
    always_comb begin
        state_d    = state_q;
        cur_half_d = cur_half_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        ready_d    = ready_q & ~frame_ack;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        stall_drop = 1'b0;
        // An ack arriving this cycle already frees the other half.
        other_free = ~ready_d[~cur_half_q];

        case (state_q)
            ST_FILL: begin
                if (gnt_any) begin
                    wr_d    = 1'b1;
                    addr_d  = {cur_half_q, idx_q};
                    wdata_d = pack_sample(seq_q, MIC_ID_W'(gnt_idx), hold_q[gnt_idx]);
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        // Setting the ready bit overrides a same-cycle ack.
                        ready_d[cur_half_q] = 1'b1;
                        seq_d               = seq_q + 8'd1;
                        if (other_free) begin
                            cur_half_d = ~cur_half_q;
                            idx_d      = '0;
                            state_d    = ENTRY_ST;
                        end else begin
                            state_d    = ST_STALL;
                        end
                    end
                end
            end

            ST_STALL: begin
                stall_drop = gnt_any;
                if (other_free) begin
                    cur_half_d = ~cur_half_q;
                    idx_d      = '0;
                    state_d    = ENTRY_ST;
                end
            end

`ifdef MIC_RAM_WRITER_HEADER_EN
            ST_HDR: begin
                wr_d    = 1'b1;
                addr_d  = {cur_half_q, {IW{1'b0}}};
                wdata_d = pack_header(seq_q);
                idx_d   = {{(IW-1){1'b0}}, 1'b1};
                state_d = ST_FILL;
            end
`endif

            default: begin
                state_d = ENTRY_ST;
            end
        endcase
    end

    // Several drops can happen in one cycle (one per channel plus a stalled grant).
    always_comb begin
        drop_n = '0;
        for (int j = 0; j < MIC_N; j++) begin
            drop_n = drop_n + 5'(drop_vec[j]);
        end
        drop_n       = drop_n + 5'(stall_drop);
        drop_sum     = {1'b0, drop_count_q} + 17'(drop_n);
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d   = overflow_q | (drop_n != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ENTRY_ST;
            cur_half_q   <= 1'b0;
            idx_q        <= '0;
            seq_q        <= '0;
            ready_q      <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_half_q   <= cur_half_d;
            idx_q        <= idx_d;
            seq_q        <= seq_d;
            ready_q      <= ready_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ram_address    = addr_q;
    assign ram_write      = wr_q;
    assign ram_chipselect = wr_q;
    assign ram_writedata  = wdata_q;
    assign ram_byteenable = 4'hF;
    assign frame_ready    = ready_q;
    assign drop_count     = drop_count_q;
    assign overflow       = overflow_q;

endmodule
